// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: CPU-side handshake and SRAM control signals of the memory arbiter
interface mem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic [ADDR_W-1:0] if_addr, mem_addr, ram_addr;
  logic [DATA_W-1:0] if_inst, mem_wdata, mem_rdata;
  logic if_valid, mem_rd, mem_wr, mem_done, stall;
  logic ram_en_n, ram_oe_n, ram_we_n;
  modport master (
    output if_addr, mem_rd, mem_wr, mem_addr, mem_wdata,
    input  if_inst, if_valid, mem_rdata, mem_done, stall,
    input  ram_addr, ram_en_n, ram_oe_n, ram_we_n
  );
  modport slave (
    input  if_addr, mem_rd, mem_wr, mem_addr, mem_wdata,
    output if_inst, if_valid, mem_rdata, mem_done, stall,
    output ram_addr, ram_en_n, ram_oe_n, ram_we_n
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one async SRAM between instruction fetch and load/store, MEM first
module mem_arbiter #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  mem_arbiter_if.slave      bus,
  inout  wire  [DATA_W-1:0] ram_data
);
  typedef enum logic [2:0] {FETCH, DREAD, WSETUP, WPULSE, WHOLD} state_t;
  state_t state_q, state_d;
  logic acc, wr_st, fetch_st;
  logic if_valid_q, mem_done_q;
  logic [DATA_W-1:0] if_inst_q, mem_rdata_q;
  // Accept decision and next-state; the ~mem_done term drops the still-held completed request
  always_comb begin
    acc = (bus.mem_rd | bus.mem_wr) & ~mem_done_q;
    state_d = state_q;
    case (state_q)
      FETCH:   state_d = acc ? (bus.mem_wr ? WSETUP : DREAD) : FETCH;
      WSETUP:  state_d = WPULSE;
      WPULSE:  state_d = WHOLD;
      default: state_d = FETCH;
    endcase
  end
  assign fetch_st      = state_q == FETCH;
  assign wr_st         = state_q inside {WSETUP, WPULSE, WHOLD};
  assign bus.ram_addr  = fetch_st ? bus.if_addr : bus.mem_addr;
  assign bus.ram_en_n  = rst;
  assign bus.ram_oe_n  = rst | wr_st;
  assign bus.ram_we_n  = state_q != WPULSE;
  assign bus.stall     = ~rst & (~fetch_st | acc);
  assign bus.if_inst   = if_inst_q;
  assign bus.if_valid  = if_valid_q;
  assign bus.mem_rdata = mem_rdata_q;
  assign bus.mem_done  = mem_done_q;
  assign ram_data      = wr_st ? bus.mem_wdata : {DATA_W{1'bz}};
  // State register and captured read data; reset aborts any access immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= FETCH;
      if_inst_q   <= '0;
      if_valid_q  <= 1'b0;
      mem_rdata_q <= '0;
      mem_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      if_valid_q  <= fetch_st & ~acc;
      mem_done_q  <= state_q == DREAD || state_q == WHOLD;
      if_inst_q   <= fetch_st ? ram_data : if_inst_q;
      mem_rdata_q <= state_q == DREAD ? ram_data : mem_rdata_q;
    end
  end
endmodule
